// File: rtl/srv1_pkg.sv
// srv1_pkg: shared types and constants for the data-memory bridge
package srv1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    function automatic int unsigned wd_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return w < 8 ? 8 : (w > 16 ? 16 : w);
    endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// dmem_watchdog: counts bus wait cycles and flags when the limit is hit
module dmem_watchdog
    import srv1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic start,
    input  logic active,
    output logic expired
);
    localparam int unsigned W = wd_width(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    // cnt holds the number of wait cycles already completed, so the limit is reached in the last allowed cycle
    assign expired = active && cnt == W'(TIMEOUT_CYCLES - 1);

    // cleared when a request is launched, advanced once per waiting cycle
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) cnt <= '0;
        else if (start) cnt <= '0;
        else if (active) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: single-cycle core data port to req/ack bus bridge; watchdog under DMEM_BRIDGE_TIMEOUT_EN
module dmem_bridge
    import srv1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en_in,
    output logic        core_clk_en,
    input  logic        core_bus_lock,
    input  logic        core_memory_mode,
    input  logic [29:0] core_address,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_data_out,
    output logic [31:0] core_data_in,
    output logic        ext_req,
    output logic        ext_we,
    output logic [29:0] ext_addr,
    output logic [3:0]  ext_be,
    output logic [31:0] ext_wdata,
    input  logic [31:0] ext_rdata,
    input  logic        ext_ack,
    output logic        bus_error
);
    dmem_state_t state;
    logic [31:0] rdata_q;
    logic        start;
    logic        expired;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES must be within 1..65535");
    end

    assign start        = state == IDLE && clk_en_in && core_bus_lock;
    assign core_clk_en  = clk_en_in && state != REQ && !(state == IDLE && core_bus_lock);
    assign core_data_in = rdata_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic err_q;

    dmem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .start      (start),
        .active     (state == REQ),
        .expired    (expired)
    );

    // sticky timeout flag; an ack arriving on the timeout cycle still completes normally
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) err_q <= 1'b0;
        else if (state == REQ && expired && !ext_ack) err_q <= 1'b1;
    end

    assign bus_error = err_q;
`else
    assign expired   = 1'b0;
    assign bus_error = 1'b0;
`endif

    // request sequencing, captured bus fields and held read data
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state     <= IDLE;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_be    <= '0;
            ext_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ext_req   <= 1'b1;
                    ext_we    <= core_memory_mode;
                    ext_addr  <= core_address;
                    ext_be    <= core_mask;
                    ext_wdata <= core_data_out;
                    state     <= REQ;
                end
                REQ: if (ext_ack || expired) begin
                    ext_req <= 1'b0;
                    state   <= DONE;
                    if (ext_ack) begin
                        if (!ext_we) rdata_q <= ext_rdata;
                    end else begin
                        rdata_q <= DMEM_ERR_DATA;
                    end
                end
                DONE: if (clk_en_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: vector table, corner sequences and randomized accesses against a transaction-level model
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int KMAX = 4;
`else
    localparam int KMAX = 6;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en_in;
    logic        core_clk_en;
    logic        lock;
    logic        mode;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] dout;
    logic [31:0] din;
    logic        ext_req;
    logic        ext_we;
    logic [29:0] ext_addr;
    logic [3:0]  ext_be;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    int rises = 0;
    logic [31:0] exp_din;

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .async_rst_n     (rst_n),
        .clk_en_in       (clk_en_in),
        .core_clk_en     (core_clk_en),
        .core_bus_lock   (lock),
        .core_memory_mode(mode),
        .core_address    (addr),
        .core_mask       (mask),
        .core_data_out   (dout),
        .core_data_in    (din),
        .ext_req         (ext_req),
        .ext_we          (ext_we),
        .ext_addr        (ext_addr),
        .ext_be          (ext_be),
        .ext_wdata       (ext_wdata),
        .ext_rdata       (ext_rdata),
        .ext_ack         (ext_ack),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    always @(posedge ext_req) rises <= rises + 1;

    typedef struct {
        bit          we;
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          k;
        int          gap;
        int          exp_lo;
        logic [31:0] exp_din;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one core access; bus acks in the k-th request cycle (k=0: never); called at posedge+1
    task automatic access(input bit we, input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] rd, input int k, input int exp_lo, input logic [31:0] edin);
        int lo;
        int n;
        int r0;
        bit hold_ok;
        lo = 0;
        n = 0;
        r0 = rises;
        hold_ok = 1'b1;
        clk_en_in = 1'b1;
        lock = 1'b1;
        mode = we;
        addr = a;
        mask = be;
        dout = wd;
        for (int c = 0; c < 40; c++) begin
            if (ext_req) begin
                n++;
                if (ext_we !== we || ext_addr !== a || ext_be !== be || ext_wdata !== wd) hold_ok = 1'b0;
                ext_ack = (n == k);
                ext_rdata = ext_ack ? rd : $urandom;
            end else begin
                ext_ack = 1'b0;
            end
            #1;
            if (core_clk_en) break;
            lo++;
            @(posedge clk);
            #1;
        end
        ext_ack = 1'b0;
        chk("stall_cycles", 32'(lo), 32'(exp_lo));
        chk("ext_fields_held", 32'(hold_ok), 32'd1);
        chk("req_pulses", 32'(rises - r0), 32'd1);
        chk("req_low_in_done", 32'(ext_req), 32'd0);
        @(posedge clk);
        #1;
        lock = 1'b0;
        chk("core_data_in", din, edin);
    endtask

    task automatic idle(input int n);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            lock = 1'b0;
            clk_en_in = 1'($urandom_range(0, 1));
            #1;
            if (core_clk_en !== clk_en_in || ext_req !== 1'b0) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        clk_en_in = 1'b1;
        chk("idle_no_stall", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit stuck_ok;
        int r0;
        tbl[0] = '{1'b0, 30'h100,      4'hF,    32'h0,         32'h1234_5678, 3, 1, 4, 32'h1234_5678};
        tbl[1] = '{1'b1, 30'h2A,       4'b0100, 32'h00AB_0000, 32'hCAFE_F00D, 2, 0, 3, 32'h1234_5678};
        tbl[2] = '{1'b0, 30'h3FFFFFFF, 4'hF,    32'h0,         32'h89AB_CDEF, 1, 0, 2, 32'h89AB_CDEF};
        tbl[3] = '{1'b1, 30'h5,        4'b0011, 32'h0000_BEEF, 32'h0,         1, 2, 2, 32'h89AB_CDEF};
        tbl[4] = '{1'b0, 30'h0,        4'b0001, 32'h0,         32'h0000_00FF, 4, 0, 5, 32'h0000_00FF};
        tbl[5] = '{1'b1, 30'h3,        4'hF,    32'hFFFF_FFFF, 32'h7777_7777, 4, 1, 5, 32'h0000_00FF};

        rst_n = 1'b0;
        clk_en_in = 1'b1;
        lock = 1'b0;
        mode = 1'b0;
        addr = '0;
        mask = '0;
        dout = '0;
        ext_rdata = '0;
        ext_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ext_req", 32'(ext_req), 32'd0);
        chk("rst_ext_we", 32'(ext_we), 32'd0);
        chk("rst_ext_addr", 32'(ext_addr), 32'd0);
        chk("rst_ext_be", 32'(ext_be), 32'd0);
        chk("rst_ext_wdata", ext_wdata, 32'd0);
        chk("rst_core_data_in", din, 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_clk_en_nolock", 32'(core_clk_en), 32'd1);
        lock = 1'b1;
        #1;
        chk("rst_clk_en_lock", 32'(core_clk_en), 32'd0);
        lock = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            access(tbl[i].we, tbl[i].a, tbl[i].be, tbl[i].wd, tbl[i].rd, tbl[i].k, tbl[i].exp_lo, tbl[i].exp_din);
            if (tbl[i].gap > 0) idle(tbl[i].gap);
        end
        exp_din = 32'h0000_00FF;
        chk("bus_error_after_table", 32'(bus_error), 32'd0);

        // clk_en_in dropped around completion: bridge must park in DONE
        r0 = rises;
        stuck_ok = 1'b1;
        clk_en_in = 1'b1;
        lock = 1'b1;
        mode = 1'b0;
        addr = 30'h77;
        mask = 4'hF;
        @(posedge clk);
        #1;
        chk("hold_req_issued", 32'(ext_req), 32'd1);
        clk_en_in = 1'b0;
        ext_ack = 1'b1;
        ext_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        ext_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (core_clk_en !== 1'b0 || ext_req !== 1'b0) stuck_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("done_parked", 32'(stuck_ok), 32'd1);
        chk("done_no_new_req", 32'(rises - r0), 32'd1);
        clk_en_in = 1'b1;
        #1;
        chk("done_release_clk_en", 32'(core_clk_en), 32'd1);
        @(posedge clk);
        #1;
        lock = 1'b0;
        chk("done_data", din, 32'h0BAD_F00D);

        // asynchronous reset in the middle of a request
        lock = 1'b1;
        mode = 1'b1;
        addr = 30'h1234;
        mask = 4'hF;
        dout = 32'h55;
        @(posedge clk);
        #1;
        chk("midreq_req_high", 32'(ext_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreq_async_drop", 32'(ext_req), 32'd0);
        chk("midreq_addr_cleared", 32'(ext_addr), 32'd0);
        chk("midreq_data_cleared", din, 32'd0);
        lock = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ext_ack = 1'b1;
        ext_rdata = 32'hFFFF_FFFF;
        #1;
        chk("stray_ack_clk_en", 32'(core_clk_en), 32'd1);
        @(posedge clk);
        #1;
        ext_ack = 1'b0;
        chk("stray_ack_no_req", 32'(ext_req), 32'd0);
        chk("stray_ack_data", din, 32'd0);
        chk("stray_ack_idle", 32'(core_clk_en), 32'd1);
        exp_din = 32'd0;

        // randomized accesses against the transaction-level model
        for (int i = 0; i < 30; i++) begin
            bit we;
            logic [29:0] a;
            logic [3:0] be;
            logic [31:0] wd;
            logic [31:0] rd;
            int k;
            we = 1'($urandom_range(0, 1));
            a = 30'($urandom);
            be = 4'($urandom_range(1, 15));
            wd = $urandom;
            rd = $urandom;
            k = $urandom_range(1, KMAX);
            exp_din = we ? exp_din : rd;
            access(we, a, be, wd, rd, k, k + 1, exp_din);
            idle($urandom_range(0, 2));
        end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        chk("no_error_before_timeout", 32'(bus_error), 32'd0);
        access(1'b0, 30'h42, 4'hF, 32'h0, 32'h0, 0, 5, 32'hDEAD_BEEF);
        chk("timeout_bus_error", 32'(bus_error), 32'd1);
        access(1'b0, 30'h43, 4'hF, 32'h0, 32'h1357_9BDF, 2, 3, 32'h1357_9BDF);
        chk("bus_error_sticky", 32'(bus_error), 32'd1);
`else
        chk("bus_error_tied_low", 32'(bus_error), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
